l2_tag_lookup: RTL and testbench
================================

# l2_tag_lookup

Downstream consumer of the L2 read-buffer stage. Once the per-way tag, state and evict-way buffers are loaded, this block compares a request tag against every way. It then presents a registered result to the L2 control FSM through a valid/ready handshake: hit and hit way, first empty way, and the way to evict. It also tells the FSM when the round-robin eviction pointer must advance.

## Interface
- `WAYS`, 8: number of L2 ways; must be a power of two and at least 2.
- `TAG_BITS`, 14: tag width.
- `STATE_BITS`, 3: coherence state width; state 0 means INVALID.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `start` in, 1: lookup request; the buffered inputs and `req_tag` are valid in this cycle.
- `start_ready` out, 1: high only in IDLE; a request is accepted when `start && start_ready`.
- `req_tag` in, `TAG_BITS`: tag being looked up.
- `tags_buf[WAYS]` in, `TAG_BITS` each: buffered tags.
- `states_buf[WAYS]` in, `STATE_BITS` each: buffered states.
- `evict_way_buf` in, log2(`WAYS`): current round-robin pointer.
- `res_valid` out, 1: result is valid and held.
- `res_ready` in, 1: consumer accepts the result.
- `hit` out, 1: some way has a matching tag and a non-INVALID state.
- `hit_way` out, log2(`WAYS`): lowest matching way.
- `empty_found` out, 1: some way is INVALID.
- `empty_way` out, log2(`WAYS`): lowest INVALID way.
- `evict_way` out, log2(`WAYS`): chosen victim way.
- `evict_ptr_upd` out, 1: one-cycle pulse; the pointer must advance.
- `evict_ptr_next` out, log2(`WAYS`): new pointer value, `evict_way_buf`+1 modulo `WAYS`.
- `multi_hit_err` out, 1: sticky error flag; exists only when configured in.

## Operation
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - On an accepted `start`, register `req_tag`, `tags_buf`, `states_buf` and `evict_way_buf` into a stage-1 snapshot; go to CMP.
  - Inputs are never read after acceptance.
- CMP:
  - Compute per-way `match[i] = (tag == req_tag) && state != 0` and `empty[i] = (state == 0)`.
  - Priority-encode both vectors (lowest index wins) and register all result fields; go to RESP.
- RESP:
  - `res_valid` is high and every result field is stable.
  - On `res_valid && res_ready`, return to IDLE.
- Victim selection:
  - On a hit, `evict_way = hit_way`.
  - Otherwise, if `empty_found`, `evict_way = empty_way`.
  - Otherwise, `evict_way` = the snapshot `evict_way_buf`.
- Pointer update:
  - `evict_ptr_upd` pulses for one cycle in the handshake cycle, only when the result is a miss and `!empty_found`.
  - `evict_ptr_next` wraps from `WAYS`-1 to 0.
- When no way is empty, `empty_found = 0` and `empty_way = 0`. When there is no hit, `hit = 0` and `hit_way = 0`.
- A `start` asserted outside IDLE is ignored and is not queued.

## Timing
- Request accepted at edge T → CMP during T..T+1 → `res_valid` high after edge T+2.
- Minimum latency is 2 cycles. Maximum throughput is one lookup per 3 cycles with `res_ready` held high.
- The next `start` can be accepted in the cycle after the handshake.
- `res_valid` stays high with every field frozen until `res_ready` is sampled high.
- `evict_ptr_upd` is combinational and equals `res_valid && res_ready && !hit && !empty_found`.
- Reset values, asserted asynchronously:
  - FSM goes to IDLE.
  - `start_ready` = 1.
  - `res_valid`, `hit`, `empty_found`, `evict_ptr_upd` and `multi_hit_err` = 0.
  - All way fields, `evict_ptr_next` and the snapshot = 0.
- Reset during CMP or RESP aborts the lookup. No handshake and no pointer update occur.

## Configuration
- `L2_LOOKUP_MULTIHIT_CHK_EN` defined:
  - In CMP, when more than one `match` bit is set, `multi_hit_err` goes high at the same edge the result registers.
  - It stays high until reset.
  - `hit_way` is still the lowest matching way.
- Undefined: the popcount logic is absent and `multi_hit_err` is tied to 0. All other behaviour is identical.

## Structure
- The shared cache package holds:
  - the way-index, tag and state typedefs;
  - the INVALID state constant;
  - the `WAYS`, `TAG_BITS` and `STATE_BITS` defaults.
- Sub-module `l2_way_prio_enc`: a one-hot/any vector to lowest-index encoder, parameterized by `WAYS`. It is instantiated twice, for match and for empty.

## Test plan
- Hit: `WAYS`=8, `req_tag`=0x12A, way 5 tag 0x12A state 2, all other states non-zero with other tags → after 2 cycles `hit`=1, `hit_way`=5, `evict_way`=5, no `evict_ptr_upd`.
- Miss with empty ways: no match, ways 3 and 6 state 0 → `empty_found`=1, `empty_way`=3, `evict_way`=3, no update pulse.
- Full miss with wrap: all ways valid, no match, `evict_way_buf`=7 → `evict_way`=7, `evict_ptr_upd` pulses at the handshake, `evict_ptr_next`=0.
- Backpressure: `res_ready`=0 for 5 cycles, inputs changing, `start` pulsed → outputs frozen, `start_ready`=0, second start ignored; `res_ready`=1 → single handshake.
- Multi-hit (macro defined): ways 2 and 4 both match with valid state → `hit_way`=2, `multi_hit_err`=1 until reset. With the macro undefined, `multi_hit_err` stays 0.
- Reset in RESP: assert `rst` while `res_valid`=1 → all outputs take their reset values immediately, no update pulse, and `start_ready`=1 after deassertion.

Source files
------------

// File: rtl/l2_tag_lookup_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_tag_lookup_pkg                                               |
// | Brief    : Shared L2 cache types, geometry defaults and lookup FSM states. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package l2_tag_lookup_pkg;

    localparam int WAYS_DFLT       = 8;
    localparam int TAG_BITS_DFLT   = 14;
    localparam int STATE_BITS_DFLT = 3;
    localparam int WAY_IDX_BITS    = $clog2(WAYS_DFLT);

    typedef logic [WAY_IDX_BITS-1:0]    way_idx_t;
    typedef logic [TAG_BITS_DFLT-1:0]   tag_t;
    typedef logic [STATE_BITS_DFLT-1:0] state_t;

    localparam state_t STATE_INVALID = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } lookup_state_e;

endpackage
`default_nettype wire

// File: rtl/l2_tag_lookup_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_tag_lookup_if                                                |
// | Brief    : Request/result bus between L2 control FSM and tag lookup.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface l2_tag_lookup_if
    import l2_tag_lookup_pkg::*;
#(
    parameter int WAYS       = WAYS_DFLT,
    parameter int TAG_BITS   = TAG_BITS_DFLT,
    parameter int STATE_BITS = STATE_BITS_DFLT
);
    localparam int IDX_W = $clog2(WAYS);

    logic                                 start;
    logic                                 start_ready;
    logic [TAG_BITS-1:0]                  req_tag;
    logic [WAYS-1:0][TAG_BITS-1:0]        tags_buf;
    logic [WAYS-1:0][STATE_BITS-1:0]      states_buf;
    logic [IDX_W-1:0]                     evict_way_buf;
    logic                                 res_valid;
    logic                                 res_ready;
    logic                                 hit;
    logic [IDX_W-1:0]                     hit_way;
    logic                                 empty_found;
    logic [IDX_W-1:0]                     empty_way;
    logic [IDX_W-1:0]                     evict_way;
    logic                                 evict_ptr_upd;
    logic [IDX_W-1:0]                     evict_ptr_next;
    logic                                 multi_hit_err;

    modport master (
        output start, req_tag, tags_buf, states_buf, evict_way_buf, res_ready,
        input  start_ready, res_valid, hit, hit_way, empty_found, empty_way,
               evict_way, evict_ptr_upd, evict_ptr_next, multi_hit_err
    );

    modport slave (
        input  start, req_tag, tags_buf, states_buf, evict_way_buf, res_ready,
        output start_ready, res_valid, hit, hit_way, empty_found, empty_way,
               evict_way, evict_ptr_upd, evict_ptr_next, multi_hit_err
    );

endinterface
`default_nettype wire

// File: rtl/l2_way_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_way_prio_enc                                                 |
// | Brief    : Any-bit flag and lowest-set-index encoder over a way vector.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module l2_way_prio_enc #(
    parameter int WAYS = 8
) (
    input  wire logic [WAYS-1:0]         i_vec,
    output logic                         o_any,
    output logic [$clog2(WAYS)-1:0]      o_idx
);
    localparam int IDX_W = $clog2(WAYS);

    assign o_any = |i_vec;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_tag_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_tag_lookup                                                   |
// | Brief    : Snapshot, compare and registered hit/empty/victim result.       |
// |            Optional multi-hit flag: L2_LOOKUP_MULTIHIT_CHK_EN.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module l2_tag_lookup
    import l2_tag_lookup_pkg::*;
#(
    parameter int WAYS       = WAYS_DFLT,
    parameter int TAG_BITS   = TAG_BITS_DFLT,
    parameter int STATE_BITS = STATE_BITS_DFLT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    l2_tag_lookup_if.slave   bus
);
    localparam int IDX_W = $clog2(WAYS);

    lookup_state_e                    state_q, state_d;
    logic [TAG_BITS-1:0]              snap_tag_q, snap_tag_d;
    logic [WAYS-1:0][TAG_BITS-1:0]    snap_tags_q, snap_tags_d;
    logic [WAYS-1:0][STATE_BITS-1:0]  snap_states_q, snap_states_d;
    logic [IDX_W-1:0]                 snap_evict_q, snap_evict_d;

    logic                             hit_q, hit_d;
    logic [IDX_W-1:0]                 hit_way_q, hit_way_d;
    logic                             empty_found_q, empty_found_d;
    logic [IDX_W-1:0]                 empty_way_q, empty_way_d;
    logic [IDX_W-1:0]                 evict_way_q, evict_way_d;
    logic [IDX_W-1:0]                 ptr_next_q, ptr_next_d;

    logic [WAYS-1:0]                  w_match_vec;
    logic [WAYS-1:0]                  w_empty_vec;
    logic                             w_match_any;
    logic                             w_empty_any;
    logic [IDX_W-1:0]                 w_match_idx;
    logic [IDX_W-1:0]                 w_empty_idx;

    for (genvar i = 0; i < WAYS; i++) begin : g_way_cmp
        assign w_empty_vec[i] = (snap_states_q[i] == STATE_BITS'(STATE_INVALID));
        assign w_match_vec[i] = (snap_tags_q[i] == snap_tag_q) && !w_empty_vec[i];
    end

    l2_way_prio_enc #(.WAYS(WAYS)) u_match_enc (
        .i_vec (w_match_vec),
        .o_any (w_match_any),
        .o_idx (w_match_idx)
    );

    l2_way_prio_enc #(.WAYS(WAYS)) u_empty_enc (
        .i_vec (w_empty_vec),
        .o_any (w_empty_any),
        .o_idx (w_empty_idx)
    );

    always_comb begin
        state_d       = state_q;
        snap_tag_d    = snap_tag_q;
        snap_tags_d   = snap_tags_q;
        snap_states_d = snap_states_q;
        snap_evict_d  = snap_evict_q;
        hit_d         = hit_q;
        hit_way_d     = hit_way_q;
        empty_found_d = empty_found_q;
        empty_way_d   = empty_way_q;
        evict_way_d   = evict_way_q;
        ptr_next_d    = ptr_next_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    snap_tag_d    = bus.req_tag;
                    snap_tags_d   = bus.tags_buf;
                    snap_states_d = bus.states_buf;
                    snap_evict_d  = bus.evict_way_buf;
                    state_d       = ST_CMP;
                end
            end
            ST_CMP: begin
                hit_d         = w_match_any;
                hit_way_d     = w_match_idx;
                empty_found_d = w_empty_any;
                empty_way_d   = w_empty_idx;
                if (w_match_any) begin
                    evict_way_d = w_match_idx;
                end else if (w_empty_any) begin
                    evict_way_d = w_empty_idx;
                end else begin
                    evict_way_d = snap_evict_q;
                end
                // WAYS is a power of two, so the natural wrap is the modulo.
                ptr_next_d = snap_evict_q + IDX_W'(1);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            snap_tag_q    <= '0;
            snap_tags_q   <= '0;
            snap_states_q <= '0;
            snap_evict_q  <= '0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            empty_found_q <= 1'b0;
            empty_way_q   <= '0;
            evict_way_q   <= '0;
            ptr_next_q    <= '0;
        end else begin
            state_q       <= state_d;
            snap_tag_q    <= snap_tag_d;
            snap_tags_q   <= snap_tags_d;
            snap_states_q <= snap_states_d;
            snap_evict_q  <= snap_evict_d;
            hit_q         <= hit_d;
            hit_way_q     <= hit_way_d;
            empty_found_q <= empty_found_d;
            empty_way_q   <= empty_way_d;
            evict_way_q   <= evict_way_d;
            ptr_next_q    <= ptr_next_d;
        end
    end

`ifdef L2_LOOKUP_MULTIHIT_CHK_EN
    logic multi_hit_err_q, multi_hit_err_d;
    logic w_multi_match;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi_match = |(w_match_vec & (w_match_vec - WAYS'(1)));

    always_comb begin
        multi_hit_err_d = multi_hit_err_q;
        if ((state_q == ST_CMP) && w_multi_match) begin
            multi_hit_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_hit_err_q <= 1'b0;
        end else begin
            multi_hit_err_q <= multi_hit_err_d;
        end
    end

    assign bus.multi_hit_err = multi_hit_err_q;
`else
    assign bus.multi_hit_err = 1'b0;
`endif

    assign bus.start_ready    = (state_q == ST_IDLE);
    assign bus.res_valid      = (state_q == ST_RESP);
    assign bus.hit            = hit_q;
    assign bus.hit_way        = hit_way_q;
    assign bus.empty_found    = empty_found_q;
    assign bus.empty_way      = empty_way_q;
    assign bus.evict_way      = evict_way_q;
    assign bus.evict_ptr_next = ptr_next_q;
    assign bus.evict_ptr_upd  = (state_q == ST_RESP) && bus.res_ready
                                && !hit_q && !empty_found_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_tag_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_l2_tag_lookup                                                |
// | Brief    : Directed bench for l2_tag_lookup with a transaction-level model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_l2_tag_lookup;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    l2_tag_lookup_if bus ();

    l2_tag_lookup dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef L2_LOOKUP_MULTIHIT_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: 0 = waiting, 1 = comparing, 2 = holding a result.
    int         m_phase = 0;
    logic [13:0] m_req;
    logic [13:0] m_tags [W];
    logic [2:0]  m_states [W];
    int         m_ev;
    int         m_hit = 0, m_hit_way = 0, m_ef = 0, m_ew = 0, m_evict = 0, m_next = 0;
    int         m_err = 0;

    task automatic model_compute();
        int nmatch;
        nmatch = 0;
        m_hit = 0; m_hit_way = 0; m_ef = 0; m_ew = 0;
        for (int i = 0; i < W; i++) begin
            if (m_tags[i] == m_req && m_states[i] != 3'd0) begin
                if (nmatch == 0) m_hit_way = i;
                nmatch++;
                m_hit = 1;
            end
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (m_states[i] == 3'd0) begin
                m_ef = 1;
                m_ew = i;
            end
        end
        m_evict = m_hit ? m_hit_way : (m_ef ? m_ew : m_ev);
        m_next  = (m_ev + 1) % W;
        if (ERR_EN && nmatch > 1) m_err = 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_hit = 0; m_hit_way = 0; m_ef = 0; m_ew = 0;
            m_evict = 0; m_next = 0; m_err = 0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_req = bus.req_tag;
                    for (int i = 0; i < W; i++) begin
                        m_tags[i]   = bus.tags_buf[i];
                        m_states[i] = bus.states_buf[i];
                    end
                    m_ev    = int'(bus.evict_way_buf);
                    m_phase = 1;
                end
                1: begin
                    model_compute();
                    m_phase = 2;
                end
                default: if (bus.res_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("start_ready", bus.start_ready, m_phase == 0);
        chk("res_valid", bus.res_valid, m_phase == 2);
        chk("evict_ptr_upd", bus.evict_ptr_upd,
            (m_phase == 2) && bus.res_ready && !m_hit && !m_ef);
        chk("multi_hit_err", bus.multi_hit_err, m_err);
        if (m_phase == 2) begin
            chk("hit", bus.hit, m_hit);
            chk("hit_way", bus.hit_way, m_hit_way);
            chk("empty_found", bus.empty_found, m_ef);
            chk("empty_way", bus.empty_way, m_ew);
            chk("evict_way", bus.evict_way, m_evict);
            chk("evict_ptr_next", bus.evict_ptr_next, m_next);
        end
    end

    task automatic fill(input logic [13:0] base, input logic [13:0] req, input int ev);
        for (int i = 0; i < W; i++) begin
            bus.tags_buf[i]   = base + 14'(i);
            bus.states_buf[i] = 3'((i % 3) + 1);
        end
        bus.req_tag       = req;
        bus.evict_way_buf = 3'(ev);
    endtask

    task automatic scramble();
        bus.req_tag = 14'($urandom);
        for (int i = 0; i < W; i++) begin
            bus.tags_buf[i]   = 14'($urandom);
            bus.states_buf[i] = 3'($urandom);
        end
        bus.evict_way_buf = 3'($urandom);
    endtask

    // Called at posedge+1 in idle; returns at posedge+1 with the result presented.
    task automatic launch();
        bit seen;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("lat_accept_ready", bus.start_ready, 0);
        chk("lat_cmp_valid", bus.res_valid, 0);
        scramble();
        @(posedge clk); #1;
        chk("lat_resp_valid", bus.res_valid, 1);
        seen = bus.res_valid;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.res_valid;
        end
        if (!seen) begin
            n_vec++; n_bad++;
            $display("FAIL res_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic handshake(input int exp_upd);
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("hs_upd", bus.evict_ptr_upd, exp_upd);
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("hs_back_idle", bus.start_ready, 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        fill(14'h0, 14'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_empty_found", bus.empty_found, 0);
        chk("rst_ptr_next", bus.evict_ptr_next, 0);
        chk("rst_err", bus.multi_hit_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hit in way 5.
        fill(14'h200, 14'h12A, 3);
        bus.tags_buf[5] = 14'h12A;
        bus.states_buf[5] = 3'd2;
        launch();
        chk("hit_lit", bus.hit, 1);
        chk("hit_way_lit", bus.hit_way, 5);
        chk("hit_evict_lit", bus.evict_way, 5);
        handshake(0);

        // Miss with ways 3 and 6 invalid.
        fill(14'h300, 14'h12A, 1);
        bus.states_buf[3] = 3'd0;
        bus.states_buf[6] = 3'd0;
        launch();
        chk("empty_found_lit", bus.empty_found, 1);
        chk("empty_way_lit", bus.empty_way, 3);
        chk("empty_evict_lit", bus.evict_way, 3);
        chk("empty_hit_lit", bus.hit, 0);
        handshake(0);

        // Full miss, pointer wraps 7 -> 0.
        fill(14'h400, 14'h12A, 7);
        launch();
        chk("wrap_evict_lit", bus.evict_way, 7);
        chk("wrap_next_lit", bus.evict_ptr_next, 0);
        chk("wrap_empty_way_lit", bus.empty_way, 0);
        handshake(1);

        // Backpressure: inputs churn and a second start is ignored.
        fill(14'h500, 14'h503, 4);
        launch();
        for (int k = 0; k < 5; k++) begin
            scramble();
            bus.start = (k == 2);
            @(posedge clk); #1;
            chk("bp_ready_low", bus.start_ready, 0);
            chk("bp_hit_way_frozen", bus.hit_way, 3);
            chk("bp_evict_frozen", bus.evict_way, 3);
        end
        bus.start = 1'b0;
        handshake(0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_no_second_result", bus.res_valid, 0);
        end

        // Two matching ways: lowest wins, error flag per build.
        fill(14'h600, 14'h0AB, 2);
        bus.tags_buf[2] = 14'h0AB;
        bus.tags_buf[4] = 14'h0AB;
        launch();
        chk("multi_hit_way_lit", bus.hit_way, 2);
        chk("multi_err_lit", bus.multi_hit_err, int'(ERR_EN));
        handshake(0);
        fill(14'h700, 14'h123, 5);
        launch();
        chk("multi_err_sticky", bus.multi_hit_err, int'(ERR_EN));
        handshake(1);

        // Reset while a result is held.
        fill(14'h800, 14'h801, 6);
        launch();
        bus.res_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rr_res_valid", bus.res_valid, 0);
        chk("rr_upd", bus.evict_ptr_upd, 0);
        chk("rr_hit", bus.hit, 0);
        chk("rr_hit_way", bus.hit_way, 0);
        chk("rr_evict_way", bus.evict_way, 0);
        chk("rr_ptr_next", bus.evict_ptr_next, 0);
        chk("rr_err", bus.multi_hit_err, 0);
        chk("rr_start_ready", bus.start_ready, 1);
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rr_ready_after", bus.start_ready, 1);

        // One more lookup after reset to confirm normal operation resumes.
        fill(14'h900, 14'h905, 0);
        launch();
        chk("post_rst_hit_way", bus.hit_way, 5);
        handshake(0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
